bf_fetch_ctrl: RTL

Instruction fetch sequencer for the Brainfuck core. It owns the program ROM read port (ren/raddr/rdata, 1-cycle registered read latency) and presents one instruction at a time to the execute stage via valid/ready. On request it performs bracket-matching scans (forward for '[', backward for ']') with a nesting-depth counter. It also detects end-of-program (0x00) and unmatched brackets.

---
 rtl/bf_fetch_if.sv | 30 +++
 rtl/bf_fetch_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/bf_fetch_if.sv
// bf_fetch_if: bus bundle between the fetch sequencer and its neighbours.
//   ROM read port : rom_ren, rom_raddr (to ROM), rom_rdata (from ROM, one
//                   cycle after rom_ren)
//   Execute port  : instr_valid/instr_data/instr_pc (to execute),
//                   instr_ready/skip_fwd/skip_bwd (from execute)
// master = fetch controller side, slave = ROM/execute side.
interface bf_fetch_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  rom_ren;
  logic [ADDR_WIDTH-1:0] rom_raddr;
  logic [DATA_WIDTH-1:0] rom_rdata;
  logic                  instr_valid;
  logic                  instr_ready;
  logic [DATA_WIDTH-1:0] instr_data;
  logic [ADDR_WIDTH-1:0] instr_pc;
  logic                  skip_fwd;
  logic                  skip_bwd;

  modport master (
    output rom_ren, rom_raddr, instr_valid, instr_data, instr_pc,
    input  rom_rdata, instr_ready, skip_fwd, skip_bwd
  );

  modport slave (
    input  rom_ren, rom_raddr, instr_valid, instr_data, instr_pc,
    output rom_rdata, instr_ready, skip_fwd, skip_bwd
  );
endinterface

// File: rtl/bf_fetch_ctrl.sv
// bf_fetch_ctrl: Brainfuck instruction fetch sequencer.
// Reads the program ROM (1-cycle registered latency), hands one opcode at a
// time to execute over valid/ready, and on request scans for the matching
// bracket (forward for '[', backward for ']') with a nesting counter.
// Stops sticky on opcode 0x00 (halted) or on a scan fault (error).
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   bus        : bf_fetch_if.master (ROM read port + execute handshake)
//   busy       : bracket scan in progress
//   halted     : sticky, 0x00 fetched as an instruction
//   error      : sticky, unmatched bracket / scan out of range / depth overflow
//   scan_cycles: (only with BF_FETCH_PERF_EN) saturating count of scan cycles
// Optional feature macro: BF_FETCH_PERF_EN
module bf_fetch_ctrl #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH_WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  bf_fetch_if.master bus,
  output logic       busy,
  output logic       halted,
  output logic       error
`ifdef BF_FETCH_PERF_EN
  ,
  output logic [31:0] scan_cycles
`endif
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_HOLD, S_SCAN_RD, S_SCAN_CHK, S_HALT, S_ERR
  } state_e;

  localparam logic [7:0] OP_OPEN  = 8'h5B;
  localparam logic [7:0] OP_CLOSE = 8'h5D;
  localparam logic [7:0] OP_END   = 8'h00;
  localparam logic [ADDR_WIDTH-1:0]  PC_ONE = ADDR_WIDTH'(1);
  localparam logic [DEPTH_WIDTH-1:0] D_ONE  = DEPTH_WIDTH'(1);

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [DEPTH_WIDTH-1:0] depth_q, depth_d;
  logic                   dir_q, dir_d;      // 1 = backward scan
  logic                   vld_q, vld_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic [ADDR_WIDTH-1:0]  ipc_q, ipc_d;
  logic                   busy_q, busy_d;
  logic                   halted_q, halted_d;
  logic                   error_q, error_d;

  // Shared decode of the current ROM byte / held opcode.
  logic [7:0]             op_rd, op_hold;
  logic                   pc_max, pc_zero, hs, take_fwd, take_bwd;
  logic                   d_inc, d_dec, d_ovf, scan_err;
  logic [DEPTH_WIDTH-1:0] depth_nxt;

  always_comb begin
    op_rd    = bus.rom_rdata[7:0];
    op_hold  = data_q[7:0];
    pc_max   = &pc_q;
    pc_zero  = (pc_q == '0);
    hs       = vld_q && bus.instr_ready;
    take_fwd = bus.skip_fwd && (op_hold == OP_OPEN);
    take_bwd = !take_fwd && bus.skip_bwd && (op_hold == OP_CLOSE);
    // Nesting direction flips with scan direction.
    d_inc     = dir_q ? (op_rd == OP_CLOSE) : (op_rd == OP_OPEN);
    d_dec     = dir_q ? (op_rd == OP_OPEN)  : (op_rd == OP_CLOSE);
    d_ovf     = d_inc && (&depth_q);
    depth_nxt = d_inc ? depth_q + D_ONE : (d_dec ? depth_q - D_ONE : depth_q);
    // Fault if end-of-program is crossed going forward, the counter wraps,
    // or another step would leave the address space.
    scan_err  = (!dir_q && op_rd == OP_END) || d_ovf ||
                ((depth_nxt != '0) && (dir_q ? pc_zero : pc_max));
  end

  // State register (also holds the datapath flops).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FETCH;
      pc_q     <= '0;
      depth_q  <= '0;
      dir_q    <= 1'b0;
      vld_q    <= 1'b0;
      data_q   <= '0;
      ipc_q    <= '0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      depth_q  <= depth_d;
      dir_q    <= dir_d;
      vld_q    <= vld_d;
      data_q   <= data_d;
      ipc_q    <= ipc_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
      error_q  <= error_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:    state_d = S_DECODE;
      S_DECODE:   state_d = (op_rd == OP_END) ? S_HALT : S_HOLD;
      S_HOLD: begin
        if (hs) begin
          if (take_fwd)      state_d = pc_max  ? S_ERR : S_SCAN_RD;
          else if (take_bwd) state_d = pc_zero ? S_ERR : S_SCAN_RD;
          else               state_d = S_FETCH;
        end
      end
      S_SCAN_RD:  state_d = S_SCAN_CHK;
      S_SCAN_CHK: begin
        if (scan_err)               state_d = S_ERR;
        else if (depth_nxt == '0)   state_d = S_FETCH;
        else                        state_d = S_SCAN_RD;
      end
      S_HALT:     state_d = S_HALT;
      S_ERR:      state_d = S_ERR;
      default:    state_d = S_ERR;
    endcase
  end

  // Datapath next values.
  always_comb begin
    pc_d     = pc_q;
    depth_d  = depth_q;
    dir_d    = dir_q;
    vld_d    = vld_q;
    data_d   = data_q;
    ipc_d    = ipc_q;
    busy_d   = busy_q;
    halted_d = halted_q;
    error_d  = error_q;
    unique case (state_q)
      S_DECODE: begin
        if (op_rd == OP_END) begin
          halted_d = 1'b1;
        end else begin
          vld_d  = 1'b1;
          data_d = bus.rom_rdata;
          ipc_d  = pc_q;
        end
      end
      S_HOLD: begin
        if (hs) begin
          vld_d = 1'b0;
          if (take_fwd) begin
            if (pc_max) error_d = 1'b1;
            else begin
              depth_d = D_ONE;
              pc_d    = pc_q + PC_ONE;
              dir_d   = 1'b0;
              busy_d  = 1'b1;
            end
          end else if (take_bwd) begin
            if (pc_zero) error_d = 1'b1;
            else begin
              depth_d = D_ONE;
              pc_d    = pc_q - PC_ONE;
              dir_d   = 1'b1;
              busy_d  = 1'b1;
            end
          end else begin
            pc_d = pc_q + PC_ONE;
          end
        end
      end
      S_SCAN_CHK: begin
        depth_d = depth_nxt;
        if (scan_err) begin
          error_d = 1'b1;
          busy_d  = 1'b0;
        end else if (depth_nxt == '0) begin
          // Resume just past the matching bracket in either direction.
          pc_d   = pc_q + PC_ONE;
          busy_d = 1'b0;
        end else begin
          pc_d = dir_q ? pc_q - PC_ONE : pc_q + PC_ONE;
        end
      end
      default: ;
    endcase
  end

  // Outputs.
  always_comb begin
    bus.rom_ren     = !rst && (state_q == S_FETCH || state_q == S_SCAN_RD);
    bus.rom_raddr   = pc_q;
    bus.instr_valid = vld_q;
    bus.instr_data  = data_q;
    bus.instr_pc    = ipc_q;
    busy            = busy_q;
    halted          = halted_q;
    error           = error_q;
  end

`ifdef BF_FETCH_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if ((state_q == S_SCAN_RD || state_q == S_SCAN_CHK) && perf_q != 32'hFFFF_FFFF)
      perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) perf_q <= '0;
    else     perf_q <= perf_d;
  end

  assign scan_cycles = perf_q;
`endif

endmodule
